// File: rtl/btn_pkg.sv
// Shared types and default constants for the pushbutton conditioner.
package btn_pkg;

  localparam int unsigned TICK_DIV_10MHZ_1MS = 10000;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 20;
  localparam int unsigned REPEAT_DELAY_DEF   = 500;
  localparam int unsigned REPEAT_RATE_DEF    = 100;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } btn_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module ms_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_10MHZ_1MS
) (
  input  logic clk_10MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and latches presses of the active-low "next" button.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TICK_DIV_10MHZ_1MS,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic clk_10MHz,
  input  logic reset,
  input  logic btn_n,
  input  logic press_ack,
  output logic press_req,
  output logic btn_level,
  output logic press_lost
);

  localparam int unsigned DbW = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [DbW-1:0] DbTarget = DbW'(DEBOUNCE_TICKS);

  logic           sync1_q, sync2_q;
  logic           raw_p;
  logic           tick;
  btn_state_t     state_q, state_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic           accept_evt;
  logic           press_evt;
  logic           btn_level_q, btn_level_d;
  logic           press_req_q, press_req_d;
  logic           press_lost_q, press_lost_d;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_10MHz(clk_10MHz),
    .reset    (reset),
    .tick     (tick)
  );

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign raw_p = ~sync2_q;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    db_inc     = db_cnt_q + 1'b1;
    accept_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (raw_p) begin
          state_d  = StPressWait;
          db_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!raw_p) begin
          state_d = StIdle;
        end else if (tick) begin
          db_cnt_d = db_inc;
          if (db_inc == DbTarget) begin
            state_d    = StPressed;
            accept_evt = 1'b1;
          end
        end
      end
      StPressed: begin
        if (!raw_p) begin
          state_d  = StReleaseWait;
          db_cnt_d = '0;
        end
      end
      StReleaseWait: begin
        if (raw_p) begin
          state_d = StPressed;
        end else if (tick) begin
          db_cnt_d = db_inc;
          if (db_inc == DbTarget) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepW = cnt_width(REPEAT_DELAY + 1);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_RATE);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic            rep_evt;

  // Reloading to DELAY-RATE makes every later repeat land RATE ticks apart.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_inc   = rep_cnt_q + 1'b1;
    rep_evt   = 1'b0;
    if (state_q == StPressed && raw_p && tick) begin
      if (rep_inc == RepDelay) begin
        rep_evt   = 1'b1;
        rep_cnt_d = RepReload;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end else if (state_q == StIdle || state_q == StPressWait) begin
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign press_evt = accept_evt | rep_evt;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign press_evt         = accept_evt;
`endif

  // A new press overrides a coincident acknowledge.
  always_comb begin
    btn_level_d  = (state_d == StPressed) || (state_d == StReleaseWait);
    press_req_d  = press_req_q;
    if (press_evt) begin
      press_req_d = 1'b1;
    end else if (press_ack) begin
      press_req_d = 1'b0;
    end
    press_lost_d = press_lost_q | (press_evt & press_req_q & ~press_ack);
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      press_req_q  <= 1'b0;
      press_lost_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      press_req_q  <= press_req_d;
      press_lost_q <= press_lost_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign press_req  = press_req_q;
  assign press_lost = press_lost_q;

endmodule
